// File: rtl/fetch_pc_stage_pkg.sv
// Shared definitions for the fetch PC stage: FSM encoding and default datapath widths.
package fetch_pc_stage_pkg;

  localparam int unsigned ADDR_W_DEF   = 24;
  localparam int unsigned INSTR_W_DEF  = 28;
  localparam logic [23:0] RESET_PC_DEF = 24'h000000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_VALID = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_stage_perf_counters.sv
// Free-running fetch/stall event counters; only built when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch,
  input  logic        i_stall,
  output logic [31:0] o_fetched,
  output logic [31:0] o_stall
);

  logic [31:0] r_fetched;
  logic [31:0] r_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetched <= '0;
      r_stall   <= '0;
    end else begin
      if (i_fetch) r_fetched <= r_fetched + 32'd1;
      if (i_stall) r_stall   <= r_stall + 32'd1;
    end
  end

  assign o_fetched = r_fetched;
  assign o_stall   = r_stall;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: PC register, imem request FSM and valid/ready output buffer.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               redirect,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;
  logic               w_load;
  logic               w_pc_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pc_adv) r_pc <= next_pc;
      if (w_load) begin
        r_if_instr <= imem_rdata;
        r_if_pc    <= r_pc;
      end
    end
  end

  // Redirect wins over everything and throws away a coincident ack.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pc_adv     = 1'b0;
    if (redirect) begin
      w_state_next = ST_FETCH;
      w_pc_adv     = 1'b1;
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            w_load       = 1'b1;
            w_pc_adv     = 1'b1;
            w_state_next = ST_VALID;
          end
        end
        ST_VALID: begin
          if (if_ready) begin
            if (imem_ack) begin
              w_load   = 1'b1;
              w_pc_adv = 1'b1;
            end else begin
              w_state_next = ST_FETCH;
            end
          end
        end
        default: w_state_next = ST_FETCH;
      endcase
    end
  end

  assign pc_plus1  = r_pc + ADDR_W'(1);
  assign imem_addr = r_pc;
  assign if_valid  = (r_state == ST_VALID);
  assign imem_req  = !rst && ((r_state == ST_FETCH) || if_ready);
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_fetch   (w_load),
    .i_stall   (if_valid && !if_ready),
    .o_fetched (perf_fetched),
    .o_stall   (perf_stall)
  );
`endif

endmodule
